// File: rtl/serial_adder.sv
// ----------------------------------------------------------------------------
// serial_adder
//   Bit-serial adder. One accepted start loads two WIDTH-bit operands and a
//   carry-in. The block then adds one bit per clock, LSB first, using two
//   cascaded half adders. It publishes sum/cout and pulses done one cycle later.
//
// Parameters
//   WIDTH  operand/result width in bits (2..32), default 8
//
// Ports
//   clk    in   1      rising-edge clock
//   rst    in   1      asynchronous, active-high reset
//   start  in   1      begin an addition (honoured only in IDLE)
//   a      in   WIDTH  operand A, sampled on the accepted start edge
//   b      in   WIDTH  operand B, sampled on the accepted start edge
//   cin    in   1      carry-in, sampled on the accepted start edge
//   busy   out  1      high while in ADD
//   done   out  1      one-cycle pulse: sum/cout valid
//   sum    out  WIDTH  registered result (a+b+cin) mod 2^WIDTH
//   cout   out  1      registered carry-out of the MSB
//   ovf    out  1      registered signed overflow (only with
//                      SERIAL_ADDER_OVF_EN defined)
//
// Build option
//   SERIAL_ADDER_OVF_EN  adds the ovf port and its logic.
// ----------------------------------------------------------------------------
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Operand shift registers, carry flop, bit counter, sum accumulator
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_sum_sh;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;

  // Published results
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_done;
`ifdef SERIAL_ADDER_OVF_EN
  logic             r_ovf;
`endif

  // FSM decode
  logic w_load;
  logic w_step;
  logic w_last;

  // Bit-slice adder
  logic w_s1;
  logic w_c1;
  logic w_s;
  logic w_c2;
  logic w_carry_nxt;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next state and control decode
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_step      = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_load      = 1'b1;
          w_state_nxt = ADD;
        end
      end
      ADD: begin
        w_step = 1'b1;
        if (r_cnt == LAST_CNT) begin
          w_last      = 1'b1;
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Two cascaded half adders on the current LSBs
  // --------------------------------------------------------------------------
  always_comb begin
    w_s1        = r_a_sh[0] ^ r_b_sh[0];
    w_c1        = r_a_sh[0] & r_b_sh[0];
    w_s         = w_s1 ^ r_carry;
    w_c2        = w_s1 & r_carry;
    w_carry_nxt = w_c1 | w_c2;
  end

  // --------------------------------------------------------------------------
  // Serial datapath
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_sum_sh <= '0;
      r_carry  <= 1'b0;
      r_cnt    <= '0;
    end else if (w_load) begin
      r_a_sh   <= a;
      r_b_sh   <= b;
      r_sum_sh <= '0;
      r_carry  <= cin;
      r_cnt    <= '0;
    end else if (w_step) begin
      r_a_sh   <= {1'b0, r_a_sh[WIDTH-1:1]};
      r_b_sh   <= {1'b0, r_b_sh[WIDTH-1:1]};
      // New bit enters at the MSB; after WIDTH shifts bit 0 sits at [0].
      r_sum_sh <= {w_s, r_sum_sh[WIDTH-1:1]};
      r_carry  <= w_carry_nxt;
      // The counter stops at WIDTH-1 rather than wrapping.
      if (!w_last) begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Result registers: captured on the final ADD edge, so they change only when
  // DONE is entered and hold through the next operation. done follows DONE by
  // one cycle.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sum  <= '0;
      r_cout <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= (r_state == DONE);
      if (w_last) begin
        r_sum  <= {w_s, r_sum_sh[WIDTH-1:1]};
        r_cout <= w_carry_nxt;
      end
    end
  end

`ifdef SERIAL_ADDER_OVF_EN
  // On the final bit, r_carry is the carry into the MSB.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (w_last) begin
      r_ovf <= r_carry ^ w_carry_nxt;
    end
  end

  assign ovf = r_ovf;
`endif

  assign busy = (r_state == ADD);
  assign done = r_done;
  assign sum  = r_sum;
  assign cout = r_cout;

endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;

  localparam int W = 8;

  logic         clk   = 1'b0;
  logic         rst   = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;
  logic         cin   = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic         ovf;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic
  function automatic logic [W:0] add_ref(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic c);
    return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
  endfunction

  function automatic logic ovf_ref(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic c);
    logic [W:0] s;
    s = add_ref(x, y, c);
    return (x[W-1] == y[W-1]) && (s[W-1] != x[W-1]);
  endfunction

  // Timeline model: m_age = cycles since the accepted start edge (0 = idle).
  // busy for ages 1..W, done at age W+2, idle again from age W+2 onwards.
  int           m_age = 0;
  logic [W-1:0] m_a, m_b;
  logic         m_cin;
  logic [W-1:0] m_sum  = '0;
  logic         m_cout = 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
  logic         m_ovf  = 1'b0;
`endif

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_age  <= 0;
      m_sum  <= '0;
      m_cout <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      m_ovf  <= 1'b0;
`endif
    end else begin
      if ((m_age == 0 || m_age == W + 2) && start) begin
        m_age <= 1;
        m_a   <= a;
        m_b   <= b;
        m_cin <= cin;
      end else if (m_age >= 1 && m_age <= W + 1) begin
        m_age <= m_age + 1;
      end else begin
        m_age <= 0;
      end
      if (m_age == W) begin
        {m_cout, m_sum} <= add_ref(m_a, m_b, m_cin);
`ifdef SERIAL_ADDER_OVF_EN
        m_ovf <= ovf_ref(m_a, m_b, m_cin);
`endif
      end
    end
  end

  // Continuous compare on the falling edge
  always @(negedge clk) begin
    chk("busy", 32'(busy), 32'(m_age >= 1 && m_age <= W));
    chk("done", 32'(done), 32'(m_age == W + 2));
    if (m_age != W + 1) begin
      chk("sum", 32'(sum), 32'(m_sum));
      chk("cout", 32'(cout), 32'(m_cout));
`ifdef SERIAL_ADDER_OVF_EN
      chk("ovf", 32'(ovf), 32'(m_ovf));
`endif
    end
  end

  task automatic pulse_start(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xc);
    a     = xa;
    b     = xb;
    cin   = xc;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Called just after the start edge; lat = edges from start edge to the
  // edge that raises done.
  task automatic wait_done(output int lat, output int busy_cnt);
    lat      = -1;
    busy_cnt = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done) begin
        lat = k - 1;
        break;
      end
    end
  endtask

  task automatic run_dir(input string nm, input logic [W-1:0] xa, input logic [W-1:0] xb,
                         input logic xc, input logic [W-1:0] es, input logic ec,
                         input logic eo);
    int lat, bc;
    pulse_start(xa, xb, xc);
    wait_done(lat, bc);
    chk({nm, "_latency"}, 32'(lat), 32'(W + 1));
    chk({nm, "_busy_cycles"}, 32'(bc), 32'(W));
    chk({nm, "_sum"}, 32'(sum), 32'(es));
    chk({nm, "_cout"}, 32'(cout), 32'(ec));
`ifdef SERIAL_ADDER_OVF_EN
    chk({nm, "_ovf"}, 32'(ovf), 32'(eo));
`else
    if (eo === 1'bx) $display("note: unknown ovf expectation for %s", nm);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int ndone, lat, bc, prev_k;
    logic [W-1:0] held;

    // Reset state
    #1 rst = 1'b1;
    @(negedge clk);
    chk("reset_busy", 32'(busy), 32'(0));
    chk("reset_done", 32'(done), 32'(0));
    chk("reset_sum", 32'(sum), 32'(0));
    chk("reset_cout", 32'(cout), 32'(0));
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    // Directed additions
    run_dir("add_0f_01", 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0);
    run_dir("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    run_dir("add_00_00_c", 8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0);
    run_dir("add_7f_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);

    // Second start during ADD is ignored; operand changes have no effect
    pulse_start(8'h12, 8'h34, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    a = 8'h77; b = 8'h11; cin = 1'b1; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    ndone = 0;
    held  = '0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        held = sum;
      end
    end
    chk("ignore_start_done_count", 32'(ndone), 32'(1));
    chk("ignore_start_sum", 32'(held), 32'(8'h46));
    chk("ignore_start_sum_held", 32'(sum), 32'(8'h46));

    // Reset 4 cycles into ADD aborts the operation
    pulse_start(8'hC3, 8'h5A, 1'b1);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 32'(0));
    chk("abort_done", 32'(done), 32'(0));
    chk("abort_sum", 32'(sum), 32'(0));
    chk("abort_cout", 32'(cout), 32'(0));
    @(posedge clk);
    #1 rst = 1'b0;
    ndone = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("abort_no_done", 32'(ndone), 32'(0));
    run_dir("after_abort", 8'h21, 8'h42, 1'b0, 8'h63, 1'b0, 1'b0);

    // start already high when reset releases: accepted on first edge
    @(posedge clk);
    #1 rst = 1'b1;
    a = 8'h90; b = 8'h90; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(lat, bc);
    chk("rst_release_latency", 32'(lat), 32'(W + 1));
    chk("rst_release_sum", 32'(sum), 32'(8'h20));
    chk("rst_release_cout", 32'(cout), 32'(1));

    // start held high for 30 cycles
    @(posedge clk);
    #1;
    a = 8'hAA; b = 8'h55; cin = 1'b0; start = 1'b1;
    ndone  = 0;
    prev_k = 0;
    for (int k = 1; k <= 45; k++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        chk("held_sum", 32'(sum), 32'(8'hFF));
        chk("held_cout", 32'(cout), 32'(0));
        if (prev_k != 0) chk("held_spacing", 32'(k - prev_k), 32'(W + 2));
        prev_k = k;
      end
      if (k == 30) start = 1'b0;
    end
    chk("held_done_count", 32'(ndone), 32'(3));

    // Randomised operations with operand churn and stray starts during ADD
    for (int i = 0; i < 40; i++) begin
      int found;
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      pulse_start(W'($urandom), W'($urandom), 1'($urandom));
      for (int k = 1; k <= W; k++) begin
        @(posedge clk);
        #1;
        a     = W'($urandom);
        b     = W'($urandom);
        cin   = 1'($urandom);
        start = ($urandom_range(0, 3) == 0);
      end
      start = 1'b0;
      found = 0;
      for (int k = 0; k < 5; k++) begin
        @(negedge clk);
        if (done) begin
          found = 1;
          break;
        end
      end
      chk("rand_done_seen", 32'(found), 32'(1));
    end

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 8, giving the operand and result width in bits (legal range 2..32).
REQ-002 The block SHALL have one clock and an asynchronous, active-high reset, named as in the port list below.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  single-cycle request to begin an addition; honoured only in IDLE.
REQ-006 a  input  WIDTH  operand A; sampled on the accepted start edge.
REQ-007 b  input  WIDTH  operand B; sampled on the accepted start edge.
REQ-008 cin  input  1  carry-in; sampled on the accepted start edge.
REQ-009 busy  output  1  high while an addition is in progress (state ADD).
REQ-010 done  output  1  one-cycle pulse marking sum and cout as valid.
REQ-011 sum  output  WIDTH  registered result of a+b+cin, modulo 2^WIDTH.
REQ-012 cout  output  1  registered carry-out of the MSB.

Function
REQ-013 The FSM SHALL have three states: IDLE, ADD and DONE.
  - IDLE -> ADD on start=1.
  - ADD -> DONE after exactly WIDTH ADD cycles.
  - DONE -> IDLE unconditionally after one cycle.
REQ-014 On accepting start, the block SHALL load a and b into internal shift registers, load cin into the carry flop, clear the bit counter and clear the sum shift register.
REQ-015 Each ADD cycle SHALL process one bit, LSB first, as two cascaded half-adder stages.
  - Stage 1: s1 = a_i ^ b_i, c1 = a_i & b_i.
  - Stage 2: s = s1 ^ c, c2 = s1 & c.
  - The carry flop SHALL be updated with c1 | c2.
  - s SHALL be shifted into the sum register MSB-side so that bit 0 lands at sum[0] after WIDTH shifts.
REQ-016 The bit counter SHALL be clog2(WIDTH)+1 bits wide and SHALL count 0..WIDTH-1 without wrapping inside an operation.
REQ-017 Latency: with start sampled at edge E, done SHALL be high for exactly the cycle following edge E+WIDTH+1.
REQ-018 busy SHALL be high exactly in the WIDTH cycles following edge E.
REQ-019 At the DONE state, cout SHALL equal the final carry flop value.
REQ-020 sum and cout SHALL hold their values from the DONE state until the next accepted start, during which they SHALL hold their previous values until the new DONE state.
REQ-021 start asserted in ADD or DONE SHALL be ignored, with no queuing and no effect on the operation in progress.
REQ-022 Changes to a, b or cin after the accepted start edge SHALL NOT affect the result.
REQ-023 start held high continuously SHALL begin a new addition on each return to IDLE, i.e. one operation every WIDTH+2 cycles.

Reset
REQ-024 Asserting rst SHALL immediately force: state=IDLE, busy=0, done=0, sum=0, cout=0, counter=0, carry=0 and the operand registers to 0, independent of clk.
REQ-025 rst asserted mid-operation SHALL abort the addition with no done pulse, and no partial result SHALL appear on sum.
REQ-026 On the first rising edge after rst deasserts, the block SHALL accept start if start is high.

Configuration
REQ-027 The macro SERIAL_ADDER_OVF_EN SHALL control the overflow feature.
  - When defined, the block SHALL add a port ovf (output, 1 bit): the registered signed overflow, computed as the carry into the MSB XOR the carry out of the MSB. It SHALL be updated and held with the same timing as cout and SHALL reset to 0.
  - When not defined, the ovf port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-028 The bench SHALL cover these directed scenarios (WIDTH=8):
  - start, a=0x0F, b=0x01, cin=0 -> done exactly 9 cycles after the start edge, sum=0x10, cout=0; busy high for 8 cycles.
  - a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; a=0x00, b=0x00, cin=1 -> sum=0x01, cout=0.
  - Second start pulse 3 cycles into ADD with different operands -> ignored; first result unchanged; exactly one done pulse.
  - rst asserted 4 cycles into ADD -> busy=0, done=0, sum=0, cout=0 immediately; no done pulse follows; the next start completes normally.
  - start held high for 30 cycles, a=0xAA, b=0x55 -> sum=0xFF, cout=0 on every done pulse, with done pulses exactly 10 cycles apart.
  - With SERIAL_ADDER_OVF_EN defined: a=0x7F, b=0x01 -> ovf=1; a=0xFF, b=0x01 -> ovf=0, cout=1.
